coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples needed to accept a level change (2..255).
REQ-002 Parameter GAP_CYCLES, default 4: idle cycles forced between two emitted coin pulses (1..15).
REQ-003 clk  input  1  single clock for all state, rising-edge.
REQ-004 rst  input  1  reset, asynchronous assertion, active-low.
REQ-005 coin5_raw  input  1  asynchronous, bouncy 5-unit coin sensor.
REQ-006 coin10_raw  input  1  asynchronous, bouncy 10-unit coin sensor.
REQ-007 accept_en  input  1  high = coins accepted, low = coins rejected.
REQ-008 coin5  output  3  3'b001 for one cycle per accepted 5-unit coin, else 3'b000; feeds downstream vending FSM coin5 port.
REQ-009 coin10  output  3  3'b001 for one cycle per accepted 10-unit coin, else 3'b000; feeds downstream coin10 port.
REQ-010 reject  output  1  one-cycle pulse per discarded coin event.
REQ-011 busy  output  1  high while queue non-empty or output FSM not IDLE.

Function
REQ-012 Each raw input SHALL pass a 2-flop synchronizer before any other use.
REQ-013 Per channel, a debounced level SHALL change only after DEBOUNCE_CYCLES consecutive synchronized samples at the opposite value; any differing sample restarts the count.
REQ-014 A coin event SHALL be the 0->1 transition of a debounced level; a held-high sensor yields exactly one event until it debounces low again.
REQ-015 Events from both channels in the same cycle SHALL both be discarded with one reject pulse.
REQ-016 An event while accept_en=0 SHALL be discarded with a reject pulse in the following cycle.
REQ-017 Accepted events SHALL enter a 2-entry FIFO storing coin type, written the cycle after the event.
REQ-018 An event arriving with the FIFO full SHALL be dropped with a reject pulse; stored entries unaffected.
REQ-019 Output FSM states: IDLE, EMIT, GAP; IDLE->EMIT when FIFO non-empty; EMIT lasts one cycle, drives the matching output to 3'b001, pops the FIFO; EMIT->GAP; GAP holds GAP_CYCLES cycles then ->IDLE.
REQ-020 FIFO push and pop in the same cycle SHALL both succeed; occupancy unchanged.
REQ-021 Coins SHALL be emitted in arrival order; never both outputs non-zero in one cycle.
REQ-022 Latency, idle block with empty FIFO: pulse SHALL appear DEBOUNCE_CYCLES+4 cycles after the first rising edge sampling the raw input high.
REQ-023 accept_en falling SHALL NOT flush the FIFO; queued coins are still emitted.

Reset
REQ-024 rst low SHALL asynchronously clear synchronizers, debounce counters and levels (to 0), FIFO (empty), FSM (IDLE), GAP counter.
REQ-025 During and after reset until first event: coin5=coin10=3'b000, reject=0, busy=0.
REQ-026 Reset mid-EMIT or mid-GAP SHALL discard queued coins with no pulse or reject.

Configuration
REQ-027 Macro COIN_COUNT_EN defined: add output total_value (8 bits), incremented by 5 or 10 on each EMIT, saturating at 255, cleared only by reset.
REQ-028 Macro COIN_COUNT_EN undefined: total_value port and its logic absent; all other behaviour identical.

Verification
REQ-029 DEBOUNCE_CYCLES=16, clean coin5_raw high 40 cycles -> exactly one coin5=3'b001 pulse, 20 cycles after first sampling edge; reject=0.
REQ-030 coin10_raw toggling every 3 cycles for 60 cycles, then low -> no coin10 pulse, no reject.
REQ-031 Both raw inputs rise on the same cycle, held 30 cycles -> one reject pulse, no coin pulses.
REQ-032 Three accepted coins (5,10,5) debounced in quick succession, GAP_CYCLES=4 -> pulses in order 5,10,5, each separated by 4 idle cycles; busy high throughout.
REQ-033 Third event while FIFO holds 2 and FSM in GAP -> reject pulse, only two coin pulses; with COIN_COUNT_EN total_value ends at 15 for (5,10).
REQ-034 rst asserted during GAP with one coin queued -> outputs 0, busy 0 immediately; no pulse after release.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor -- debounced two-channel coin sensor front end.
//
// Each raw sensor goes through a 2-flop synchronizer and a debouncer;
// the rising edge of a debounced level is a coin event. Accepted events
// are queued in a 2-entry FIFO. An output FSM (IDLE/EMIT/GAP) replays
// them as one-cycle 3'b001 pulses with enforced spacing between pulses.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   coin5_raw     bouncy 5-unit sensor (asynchronous)
//   coin10_raw    bouncy 10-unit sensor (asynchronous)
//   accept_en     1 = accept coins, 0 = reject them
//   coin5/coin10  3'b001 for one cycle per emitted coin
//   reject        one-cycle pulse per discarded coin event
//   busy          FIFO non-empty or FSM not IDLE
//   total_value   running coin value, saturating (only with COIN_COUNT_EN)
//
// Optional feature: define COIN_COUNT_EN to add the total_value output.

// Per-channel synchronizer + debouncer + rise detector.
module coin_acceptor_chan #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic ev
);
    logic       sync1_q, sync2_q;
    logic       lvl_q, lvl_d, prev_q, ev_q;
    logic [7:0] cnt_q, cnt_d;

    // Any sample equal to the current level restarts the run count.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = 8'd0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) lvl_d = sync2_q;
            else                                  cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= 8'd0;
            prev_q  <= 1'b0;
            ev_q    <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            prev_q  <= lvl_q;
            ev_q    <= lvl_q & ~prev_q;
        end
    end

    assign ev = ev_q;
endmodule

module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned GAP_CYCLES      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin5_raw,
    input  logic       coin10_raw,
    input  logic       accept_en,
    output logic [2:0] coin5,
    output logic [2:0] coin10,
    output logic       reject,
    output logic       busy
`ifdef COIN_COUNT_EN
    ,
    output logic [7:0] total_value
`endif
);
    localparam int NUM_LANES = 2;   // lane 0 = 5-unit, lane 1 = 10-unit

    // The IDLE cycle that re-arbitrates after GAP is part of the spacing,
    // so GAP itself is held one cycle less. GAP never lasts under one cycle.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES >= 2) ? 4'(GAP_CYCLES - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    logic [NUM_LANES-1:0] raw, ev;
    assign raw = {coin10_raw, coin5_raw};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        coin_acceptor_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
            .clk (clk),
            .rst (rst),
            .raw (raw[g]),
            .ev  (ev[g])
        );
    end

    state_t     state_q;
    logic [3:0] gap_q;
    logic [2:0] coin5_q, coin10_q;
    logic       reject_q, reject_d;

    // FIFO entry: 0 = 5-unit coin, 1 = 10-unit coin.
    logic [1:0] mem_q, mem_d;
    logic       wr_q, wr_d, rd_q, rd_d;
    logic [1:0] fcnt_q, fcnt_d;
    logic       push, pop, head;

    assign head = mem_q[rd_q];
    assign pop  = (state_q == EMIT);

    // Simultaneous events are ambiguous, so both are dropped as one reject.
    always_comb begin
        push     = 1'b0;
        reject_d = 1'b0;
        if (ev[0] && ev[1]) begin
            reject_d = 1'b1;
        end else if (ev[0] || ev[1]) begin
            if (!accept_en || fcnt_q == 2'd2) reject_d = 1'b1;
            else                              push     = 1'b1;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = ev[1];
        wr_d   = wr_q ^ push;
        rd_d   = rd_q ^ pop;
        fcnt_d = fcnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= 2'b00;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            fcnt_q   <= 2'd0;
            reject_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            fcnt_q   <= fcnt_d;
            reject_q <= reject_d;
        end
    end

    // Output FSM; pulse registers are loaded on entry to EMIT so the
    // pulse coincides with the EMIT cycle (the pop happens as EMIT ends).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gap_q    <= 4'd0;
            coin5_q  <= 3'b000;
            coin10_q <= 3'b000;
        end else begin
            case (state_q)
                IDLE: if (fcnt_q != 2'd0) begin
                    state_q  <= EMIT;
                    coin5_q  <= {2'b00, ~head};
                    coin10_q <= {2'b00,  head};
                end
                EMIT: begin
                    state_q  <= GAP;
                    gap_q    <= GAP_LOAD;
                    coin5_q  <= 3'b000;
                    coin10_q <= 3'b000;
                end
                GAP: begin
                    if (gap_q == 4'd0) state_q <= IDLE;
                    else               gap_q   <= gap_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef COIN_COUNT_EN
    logic [7:0] total_q, total_d;
    logic [8:0] sum;

    always_comb begin
        sum     = {1'b0, total_q} + (head ? 9'd10 : 9'd5);
        total_d = total_q;
        if (state_q == EMIT) total_d = sum[8] ? 8'hFF : sum[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) total_q <= 8'd0;
        else      total_q <= total_d;
    end

    assign total_value = total_q;
`endif

    assign coin5  = coin5_q;
    assign coin10 = coin10_q;
    assign reject = reject_q;
    assign busy   = (fcnt_q != 2'd0) || (state_q != IDLE);
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a default instance (debounce 16, gap 4)
// and a fast instance (debounce 2, gap 15) used to fill the FIFO.
// Times are recorded relative to the first clock edge after a test's first drive.
module tb_coin_acceptor;
  logic clk = 1'b0, rst = 1'b0;
  logic coin5_raw = 1'b0, coin10_raw = 1'b0, accept_en = 1'b1;
  logic f5_raw = 1'b0, f10_raw = 1'b0;
  logic [2:0] coin5, coin10, f_coin5, f_coin10;
  logic reject, busy, f_reject, f_busy;
`ifdef COIN_COUNT_EN
  logic [7:0] total_value, f_total;
`endif

  int checks = 0, errors = 0;
  int edge_n = 0, base = 0, rel = 0, bad = 0;
  int p_typ[$], p_t[$], r_t[$], f_typ[$], f_t[$], fr_t[$];
  bit bz [0:199];

  always #5 clk = ~clk;

  coin_acceptor #(.DEBOUNCE_CYCLES(16), .GAP_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
    .accept_en(accept_en), .coin5(coin5), .coin10(coin10),
    .reject(reject), .busy(busy)
`ifdef COIN_COUNT_EN
    , .total_value(total_value)
`endif
  );

  coin_acceptor #(.DEBOUNCE_CYCLES(2), .GAP_CYCLES(15)) u_fast (
    .clk(clk), .rst(rst), .coin5_raw(f5_raw), .coin10_raw(f10_raw),
    .accept_en(accept_en), .coin5(f_coin5), .coin10(f_coin10),
    .reject(f_reject), .busy(f_busy)
`ifdef COIN_COUNT_EN
    , .total_value(f_total)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic clr();
    p_typ.delete(); p_t.delete(); r_t.delete();
    f_typ.delete(); f_t.delete(); fr_t.delete();
    for (int i = 0; i < 200; i++) bz[i] = 1'b0;
    base = edge_n;
  endtask

  // One clock: record edge index, then sample both instances on the falling edge.
  task automatic step();
    @(posedge clk);
    rel = edge_n - base;
    edge_n++;
    @(negedge clk);
    if (coin5 != 3'd0)  begin if (coin5 != 3'd1) bad++;  p_typ.push_back(5);  p_t.push_back(rel); end
    if (coin10 != 3'd0) begin if (coin10 != 3'd1) bad++; p_typ.push_back(10); p_t.push_back(rel); end
    if (coin5 != 3'd0 && coin10 != 3'd0) bad++;
    if (reject) r_t.push_back(rel);
    if (rel >= 0 && rel < 200) bz[rel] = busy;
    if (f_coin5 != 3'd0)  begin if (f_coin5 != 3'd1) bad++;  f_typ.push_back(5);  f_t.push_back(rel); end
    if (f_coin10 != 3'd0) begin if (f_coin10 != 3'd1) bad++; f_typ.push_back(10); f_t.push_back(rel); end
    if (f_coin5 != 3'd0 && f_coin10 != 3'd0) bad++;
    if (f_reject) fr_t.push_back(rel);
  endtask

  initial begin
    int ones;
    // reset state
    clr();
    for (int i = 0; i < 3; i++) step();
    chk("rst_c5", coin5, 0); chk("rst_c10", coin10, 0);
    chk("rst_rej", reject, 0); chk("rst_busy", busy, 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("post_rst_busy", busy, 0); chk("post_rst_c5", coin5, 0);

    // clean coin5: one pulse, 20 edges after first sampling edge
    clr();
    for (int i = 0; i < 70; i++) begin coin5_raw = (i < 40); step(); end
    chk("c5_n", p_t.size(), 1); chk("c5_typ", at(p_typ, 0), 5);
    chk("c5_t", at(p_t, 0), 20); chk("c5_rej", r_t.size(), 0);

    // coin10 toggling every 3 cycles never debounces
    clr();
    for (int i = 0; i < 100; i++) begin coin10_raw = (i < 60) && ((i / 3) % 2 == 0); step(); end
    chk("bnc_n", p_t.size(), 0); chk("bnc_rej", r_t.size(), 0);

    // both channels together: one reject, no coin
    clr();
    for (int i = 0; i < 60; i++) begin coin5_raw = (i < 30); coin10_raw = (i < 30); step(); end
    chk("both_n", p_t.size(), 0); chk("both_rej_n", r_t.size(), 1);
    chk("both_rej_t", at(r_t, 0), 19);

    // accept_en low: reject the cycle after the event
    clr();
    accept_en = 1'b0;
    for (int i = 0; i < 60; i++) begin coin5_raw = (i < 30); step(); end
    accept_en = 1'b1;
    chk("dis_n", p_t.size(), 0); chk("dis_rej_n", r_t.size(), 1);
    chk("dis_rej_t", at(r_t, 0), 19);

    // 5 then 10 two cycles later: push+pop coincide; accept_en drops after
    // queueing and the queued coin is still emitted 4 idle cycles later
    clr();
    for (int i = 0; i < 60; i++) begin
      coin5_raw = (i < 30); coin10_raw = (i >= 2) && (i < 32);
      if (i == 22) accept_en = 1'b0;
      step();
    end
    accept_en = 1'b1;
    chk("seq_n", p_t.size(), 2);
    chk("seq_typ0", at(p_typ, 0), 5);  chk("seq_t0", at(p_t, 0), 20);
    chk("seq_typ1", at(p_typ, 1), 10); chk("seq_t1", at(p_t, 1), 25);
    chk("seq_rej", r_t.size(), 0);
    ones = 0;
    for (int i = 19; i <= 28; i++) ones += int'(bz[i]);
    chk("seq_busy_pre", int'(bz[18]), 0); chk("seq_busy_win", ones, 10);
    chk("seq_busy_post", int'(bz[29]), 0);

    // reset in GAP with coin10 queued: all quiet, nothing after release
    clr();
    for (int i = 0; i < 60; i++) begin
      coin5_raw = (i < 22); coin10_raw = (i >= 2) && (i < 22);
      if (i == 22) begin
        rst = 1'b0;
        #1;
        chk("mid_c5", coin5, 0); chk("mid_c10", coin10, 0);
        chk("mid_rej", reject, 0); chk("mid_busy", busy, 0);
      end
      if (i == 25) rst = 1'b1;
      step();
    end
    chk("mid_n", p_t.size(), 1); chk("mid_t0", at(p_t, 0), 20);
    chk("mid_rej_n", r_t.size(), 0);

    // fast instance: 5 emitted, 10 and 5 queued in GAP, 4th event rejected
    clr();
    for (int i = 0; i < 60; i++) begin
      f5_raw  = (i < 4) || (i >= 8 && i < 12);
      f10_raw = (i >= 4 && i < 8) || (i >= 12 && i < 16);
      step();
    end
    chk("full_n", f_t.size(), 3);
    chk("full_typ0", at(f_typ, 0), 5);  chk("full_t0", at(f_t, 0), 6);
    chk("full_typ1", at(f_typ, 1), 10); chk("full_t1", at(f_t, 1), 22);
    chk("full_typ2", at(f_typ, 2), 5);  chk("full_t2", at(f_t, 2), 38);
    chk("full_rej_n", fr_t.size(), 1);  chk("full_rej_t", at(fr_t, 0), 17);
    chk("full_busy_end", f_busy, 0);
`ifdef COIN_COUNT_EN
    chk("full_total", f_total, 20);
    chk("main_total", total_value, 0);
`endif

    chk("pulse_fmt", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
